// File: rtl/stopwatch_pkg.sv
// Shared state encoding for the stopwatch lap controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_RECALL = 2'd3
    } sw_state_t;

endpackage

// File: rtl/btn_press_classifier.sv
// Synchronises one push-button and classifies each press as short or long,
// measuring hold time in base ticks.
module btn_press_classifier #(
    parameter int HOLD_TICKS = 300
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_tick,
    input  logic i_btn,
    output logic o_short_p,
    output logic o_long_p
);

    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

    logic [1:0]    r_sync;
    logic          r_level_q;
    logic [HW-1:0] r_hold;
    logic          r_long_done;
    logic          r_short_p;
    logic          r_long_p;
    logic          w_level;
    logic [HW-1:0] w_hold_inc;

    assign w_level    = r_sync[1];
    assign w_hold_inc = r_hold + HW'(1);

    // Once a long press has fired the counter freezes until release so that
    // neither a second long pulse nor a short pulse can follow it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync      <= '0;
            r_level_q   <= 1'b0;
            r_hold      <= '0;
            r_long_done <= 1'b0;
            r_short_p   <= 1'b0;
            r_long_p    <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_btn};
            r_level_q <= w_level;
            r_short_p <= 1'b0;
            r_long_p  <= 1'b0;
            if (!w_level) begin
                r_hold      <= '0;
                r_long_done <= 1'b0;
                if (r_level_q && !r_long_done) begin
                    r_short_p <= 1'b1;
                end
            end else if (i_tick && !r_long_done) begin
                r_hold <= w_hold_inc;
                if (w_hold_inc == HOLD_LAST) begin
                    r_long_p    <= 1'b1;
                    r_long_done <= 1'b1;
                end
            end
        end
    end

    assign o_short_p = r_short_p;
    assign o_long_p  = r_long_p;

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Two-button stopwatch with lap memory, recall mode and two-digit display mux.
// Define STOPWATCH_LAP_OVERWRITE_EN to make the lap memory a circular buffer.
module stopwatch_lap_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ   = 125_000_000,
    parameter int TICK_HZ    = 100,
    parameter int WRAP_SEC   = 60,
    parameter int LAP_DEPTH  = 5,
    parameter int HOLD_TICKS = 300,
    localparam int SEC_W = $clog2(WRAP_SEC),
    localparam int CNT_W = $clog2(LAP_DEPTH + 1),
    localparam int IDX_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_btn_ss,
    input  logic             i_btn_lap,
    output logic [SEC_W-1:0] o_sec_out,
    output logic [3:0]       o_digit_tens,
    output logic [3:0]       o_digit_ones,
    output logic [3:0]       o_disp_digit,
    output logic             o_disp_sel,
    output logic [1:0]       o_state_out,
    output logic [CNT_W-1:0] o_lap_count,
    output logic             o_lap_full,
    output logic [IDX_W-1:0] o_recall_idx
);

    localparam int DIV   = CLK_FREQ / TICK_HZ;
    localparam int DIV_W = $clog2(DIV);
    localparam int SUB_W = (TICK_HZ > 1) ? $clog2(TICK_HZ) : 1;

    logic [DIV_W-1:0] r_div;
    logic             r_tick;
    logic             r_disp_sel;
    logic [SUB_W-1:0] r_sub;
    logic [SEC_W-1:0] r_sec;
    sw_state_t        r_state;
    sw_state_t        w_state_next;
    logic [SEC_W-1:0] r_laps [LAP_DEPTH];
    logic [CNT_W-1:0] r_lap_count;
    logic [IDX_W-1:0] r_recall_idx;

    logic             w_ss_short;
    logic             w_ss_long;
    logic             w_lap_short;
    logic             w_lap_long;
    logic             w_push;
    logic             w_clear;
    logic             w_advance;
    logic             w_enter_recall;
    logic             w_full;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic [SEC_W-1:0] w_sec_disp;
    logic [7:0]       w_sec8;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_div      <= '0;
            r_tick     <= 1'b0;
            r_disp_sel <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (r_div == DIV_W'(DIV - 1)) begin
                r_div  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
            if (r_tick) begin
                r_disp_sel <= ~r_disp_sel;
            end
        end
    end

    btn_press_classifier #(.HOLD_TICKS(HOLD_TICKS)) u_cls_ss (
        .CLK       (CLK),
        .RST       (RST),
        .i_tick    (r_tick),
        .i_btn     (i_btn_ss),
        .o_short_p (w_ss_short),
        .o_long_p  (w_ss_long)
    );

    btn_press_classifier #(.HOLD_TICKS(HOLD_TICKS)) u_cls_lap (
        .CLK       (CLK),
        .RST       (RST),
        .i_tick    (r_tick),
        .i_btn     (i_btn_lap),
        .o_short_p (w_lap_short),
        .o_long_p  (w_lap_long)
    );

    assign w_full   = (r_lap_count == CNT_W'(LAP_DEPTH));
    assign w_wr_idx = IDX_W'(r_lap_count);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Clear outranks everything; any start/stop event swallows a lap event.
    always_comb begin
        w_state_next   = r_state;
        w_push         = 1'b0;
        w_clear        = 1'b0;
        w_advance      = 1'b0;
        w_enter_recall = 1'b0;
        if (w_lap_long && r_state != ST_IDLE) begin
            w_state_next = ST_IDLE;
            w_clear      = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ss_short) w_state_next = ST_RUN;
                end
                ST_RUN, ST_PAUSE: begin
                    if (w_ss_short) begin
                        w_state_next = (r_state == ST_RUN) ? ST_PAUSE : ST_RUN;
                    end else if (w_ss_long) begin
                        w_state_next   = ST_RECALL;
                        w_enter_recall = 1'b1;
                    end else if (w_lap_short) begin
                        w_push = 1'b1;
                    end
                end
                ST_RECALL: begin
                    if (w_ss_short) begin
                        w_state_next = ST_PAUSE;
                    end else if (!w_ss_long && w_lap_short && r_lap_count != '0) begin
                        w_advance = 1'b1;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || w_clear) begin
            r_sub <= '0;
            r_sec <= '0;
        end else if (r_state == ST_RUN && r_tick) begin
            if (r_sub == SUB_W'(TICK_HZ - 1)) begin
                r_sub <= '0;
                r_sec <= (r_sec == SEC_W'(WRAP_SEC - 1)) ? '0 : r_sec + SEC_W'(1);
            end else begin
                r_sub <= r_sub + SUB_W'(1);
            end
        end
    end

`ifdef STOPWATCH_LAP_OVERWRITE_EN
    logic [IDX_W-1:0] r_wptr;
    logic [IDX_W:0]   w_rd_sum;

    assign w_rd_sum = {1'b0, r_wptr} + {1'b0, r_recall_idx};
    assign w_rd_idx = (w_rd_sum >= (IDX_W + 1)'(LAP_DEPTH))
                    ? IDX_W'(w_rd_sum - (IDX_W + 1)'(LAP_DEPTH))
                    : IDX_W'(w_rd_sum);
`else
    assign w_rd_idx = r_recall_idx;
`endif

    // The write pointer only moves once the buffer is full; until then slot 0 is the oldest.
    always_ff @(posedge CLK) begin
        if (RST || w_clear) begin
            for (int i = 0; i < LAP_DEPTH; i++) begin
                r_laps[i] <= '0;
            end
            r_lap_count  <= '0;
            r_recall_idx <= '0;
`ifdef STOPWATCH_LAP_OVERWRITE_EN
            r_wptr       <= '0;
`endif
        end else begin
            if (w_push) begin
                if (!w_full) begin
                    r_laps[w_wr_idx] <= r_sec;
                    r_lap_count      <= r_lap_count + CNT_W'(1);
                end
`ifdef STOPWATCH_LAP_OVERWRITE_EN
                else begin
                    r_laps[r_wptr] <= r_sec;
                    r_wptr <= (r_wptr == IDX_W'(LAP_DEPTH - 1)) ? '0 : r_wptr + IDX_W'(1);
                end
`endif
            end
            if (w_enter_recall) begin
                r_recall_idx <= '0;
            end else if (w_advance) begin
                r_recall_idx <= (CNT_W'(r_recall_idx) + CNT_W'(1) == r_lap_count)
                              ? '0 : r_recall_idx + IDX_W'(1);
            end
        end
    end

    always_comb begin
        w_sec_disp = r_sec;
        if (r_state == ST_RECALL) begin
            w_sec_disp = (r_lap_count != '0) ? r_laps[w_rd_idx] : '0;
        end
    end

    assign w_sec8       = 8'(w_sec_disp);
    assign o_sec_out    = w_sec_disp;
    assign o_digit_tens = 4'(w_sec8 / 8'd10);
    assign o_digit_ones = 4'(w_sec8 % 8'd10);
    assign o_disp_digit = r_disp_sel ? o_digit_tens : o_digit_ones;
    assign o_disp_sel   = r_disp_sel;
    assign o_state_out  = r_state;
    assign o_lap_count  = r_lap_count;
    assign o_lap_full   = w_full;
    assign o_recall_idx = r_recall_idx;

endmodule
